frame_buf_ctrl: RTL and testbench

Single-clock ping-pong scheduler for the two-bank frame buffer. It sequences pixel writes from the capture source into one bank while the display side reads the other bank. It hands completed frames to the reader only at a reader frame boundary, so neither side can tear a frame. It generates the registered enables, addresses, bank selects and write data that drive the frame buffer's write and read ports.

---
 rtl/frame_buf_ctrl.sv | 177 +++++++++++++++++
 tb/tb_frame_buf_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buf_ctrl.sv
// rtl/frame_buf_ctrl.sv - ping-pong scheduler for a two-bank frame buffer
// The writer fills the back bank, and the reader only swaps banks at its own start of frame.
module frame_buf_ctrl #(
   parameter int ADDR_WIDTH   = 19,
   parameter int FRAME_PIXELS = 307200,
   parameter int DATA_WIDTH   = 24
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_valid_in,
   input  logic                  wr_sof_in,
   input  logic [DATA_WIDTH-1:0] wr_data_in,
   input  logic                  rd_req_in,
   input  logic                  rd_sof_in,
   output logic                  wr_en_out,
   output logic                  wr_bank_out,
   output logic [ADDR_WIDTH-1:0] wr_addr_out,
   output logic [DATA_WIDTH-1:0] wr_data_out,
   output logic                  rd_en_out,
   output logic                  rd_bank_out,
   output logic [ADDR_WIDTH-1:0] rd_addr_out,
   output logic                  blank_out,
   output logic                  wr_err_out,
   output logic                  rd_err_out,
   output logic [7:0]            frame_cnt_out
);
   typedef enum logic {W_IDLE, W_FILL} wr_state_t;
   typedef enum logic [1:0] {R_IDLE, R_READ, R_END} rd_state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

   wr_state_t             wr_state_q, wr_state_d;
   rd_state_t             rd_state_q, rd_state_d;
   logic                  disp_bank_q, disp_bank_d;
   logic                  pending_q, pending_d;
   logic                  frame_valid_q, frame_valid_d;
   logic                  wr_en_q, wr_en_d;
   logic                  wr_bank_q, wr_bank_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  wr_err_q, wr_err_d;
   logic                  rd_en_q, rd_en_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  rd_err_q, rd_err_d;
   logic                  blank_q, blank_d;
   logic [7:0]            frame_cnt_q, frame_cnt_d;
   logic                  rd_swap;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_state_q    <= W_IDLE;
         rd_state_q    <= R_IDLE;
         disp_bank_q   <= 1'b0;
         pending_q     <= 1'b0;
         frame_valid_q <= 1'b0;
         wr_en_q       <= 1'b0;
         wr_bank_q     <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         wr_err_q      <= 1'b0;
         rd_en_q       <= 1'b0;
         rd_addr_q     <= '0;
         rd_err_q      <= 1'b0;
         blank_q       <= 1'b1;
         frame_cnt_q   <= 8'd0;
      end else begin
         wr_state_q    <= wr_state_d;
         rd_state_q    <= rd_state_d;
         disp_bank_q   <= disp_bank_d;
         pending_q     <= pending_d;
         frame_valid_q <= frame_valid_d;
         wr_en_q       <= wr_en_d;
         wr_bank_q     <= wr_bank_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         wr_err_q      <= wr_err_d;
         rd_en_q       <= rd_en_d;
         rd_addr_q     <= rd_addr_d;
         rd_err_q      <= rd_err_d;
         blank_q       <= blank_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   // Reader: the bank swap is evaluated before the writer so a same-cycle writer sof sees the new bank.
   always_comb begin
      rd_state_d  = rd_state_q;
      rd_en_d     = 1'b0;
      rd_addr_d   = rd_addr_q;
      rd_err_d    = 1'b0;
      blank_d     = blank_q;
      disp_bank_d = disp_bank_q;
      rd_swap     = 1'b0;
      if (rd_req_in) begin
         if (rd_sof_in) begin
            if (pending_q) begin
               rd_swap     = 1'b1;
               disp_bank_d = wr_bank_q;
            end
            if (frame_valid_q) begin
               rd_en_d    = 1'b1;
               rd_addr_d  = '0;
               blank_d    = 1'b0;
               rd_state_d = (LAST_ADDR == '0) ? R_END : R_READ;
            end else begin
               blank_d    = 1'b1;
               rd_state_d = R_IDLE;
            end
         end else begin
            case (rd_state_q)
               R_READ: begin
                  rd_en_d   = 1'b1;
                  rd_addr_d = rd_addr_q + ADDR_ONE;
                  if (rd_addr_d == LAST_ADDR) begin
                     rd_state_d = R_END;
                  end
               end
               R_END:   rd_err_d = 1'b1;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      wr_state_d    = wr_state_q;
      wr_en_d       = 1'b0;
      wr_bank_d     = wr_bank_q;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      wr_err_d      = 1'b0;
      pending_d     = pending_q && !rd_swap;
      frame_valid_d = frame_valid_q;
      frame_cnt_d   = frame_cnt_q;
      if (wr_valid_in) begin
         if (wr_sof_in) begin
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            if (wr_state_q == W_IDLE) begin
               wr_bank_d = ~disp_bank_d;
               pending_d = 1'b0;
            end else begin
               wr_err_d  = 1'b1;
            end
         end else if (wr_state_q == W_FILL) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wr_addr_q + ADDR_ONE;
         end else begin
            wr_err_d  = 1'b1;
         end
      end
      if (wr_en_d) begin
         wr_data_d = wr_data_in;
         if (wr_addr_d == LAST_ADDR) begin
            pending_d     = 1'b1;
            frame_valid_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 8'd1;
            wr_state_d    = W_IDLE;
         end else begin
            wr_state_d    = W_FILL;
         end
      end
   end

   assign wr_en_out     = wr_en_q;
   assign wr_bank_out   = wr_bank_q;
   assign wr_addr_out   = wr_addr_q;
   assign wr_data_out   = wr_data_q;
   assign wr_err_out    = wr_err_q;
   assign rd_en_out     = rd_en_q;
   assign rd_bank_out   = disp_bank_q;
   assign rd_addr_out   = rd_addr_q;
   assign rd_err_out    = rd_err_q;
   assign blank_out     = blank_q;
   assign frame_cnt_out = frame_cnt_q;
endmodule

// File: tb/tb_frame_buf_ctrl.sv
// tb/tb_frame_buf_ctrl.sv - directed table, corner sequences and random run against a frame-level model
// The model tracks frames, banks and pixel indices as plain integers.
module tb_frame_buf_ctrl;
   localparam int AW = 19;
   localparam int DW = 24;
   localparam int FP = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_valid_in, wr_sof_in, rd_req_in, rd_sof_in;
   logic [DW-1:0] wr_data_in;
   logic          wr_en_out, wr_bank_out, rd_en_out, rd_bank_out;
   logic          blank_out, wr_err_out, rd_err_out;
   logic [AW-1:0] wr_addr_out, rd_addr_out;
   logic [DW-1:0] wr_data_out;
   logic [7:0]    frame_cnt_out;

   always #5 clk = ~clk;

   frame_buf_ctrl #(.ADDR_WIDTH(AW), .FRAME_PIXELS(FP), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset),
      .wr_valid_in(wr_valid_in), .wr_sof_in(wr_sof_in), .wr_data_in(wr_data_in),
      .rd_req_in(rd_req_in), .rd_sof_in(rd_sof_in),
      .wr_en_out(wr_en_out), .wr_bank_out(wr_bank_out), .wr_addr_out(wr_addr_out),
      .wr_data_out(wr_data_out), .rd_en_out(rd_en_out), .rd_bank_out(rd_bank_out),
      .rd_addr_out(rd_addr_out), .blank_out(blank_out), .wr_err_out(wr_err_out),
      .rd_err_out(rd_err_out), .frame_cnt_out(frame_cnt_out)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Model: reader mode 0 = no frame in progress, 1 = reading, 2 = frame exhausted.
   bit            m_filling, m_wbank, m_disp, m_pending, m_have_frame, m_blank;
   int            m_widx, m_ridx, m_rmode, m_cnt;
   logic [DW-1:0] m_wdata;
   bit            e_wen, e_werr, e_ren, e_rerr;

   typedef struct {
      bit          wv, ws;
      logic [23:0] wd;
      bit          rr, rs;
      bit          wen, wbank;
      int          waddr;
      bit          ren, rbank;
      int          raddr;
      bit          blank, werr, rerr;
      int          cnt;
   } vec_t;

   vec_t tbl[28];

   function automatic vec_t mk(bit wv, bit ws, logic [23:0] wd, bit rr, bit rs,
                               bit wen, bit wbank, int waddr, bit ren, bit rbank, int raddr,
                               bit blank, bit werr, bit rerr, int cnt);
      vec_t v;
      v.wv = wv; v.ws = ws; v.wd = wd; v.rr = rr; v.rs = rs;
      v.wen = wen; v.wbank = wbank; v.waddr = waddr; v.ren = ren; v.rbank = rbank;
      v.raddr = raddr; v.blank = blank; v.werr = werr; v.rerr = rerr; v.cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic model_reset();
      m_filling = 0; m_wbank = 0; m_disp = 0; m_pending = 0; m_have_frame = 0; m_blank = 1;
      m_widx = 0; m_ridx = 0; m_rmode = 0; m_cnt = 0; m_wdata = '0;
      e_wen = 0; e_werr = 0; e_ren = 0; e_rerr = 0;
   endtask

   task automatic model_step(input bit wv, input bit ws, input logic [DW-1:0] wd,
                             input bit rr, input bit rs);
      bit had_pending, had_frame, wrote;
      had_pending = m_pending;
      had_frame   = m_have_frame;
      e_wen = 0; e_werr = 0; e_ren = 0; e_rerr = 0;
      if (rr && rs) begin
         if (had_pending) begin
            m_disp    = m_wbank;
            m_pending = 0;
         end
         if (had_frame) begin
            e_ren = 1; m_ridx = 0; m_blank = 0;
            m_rmode = (FP == 1) ? 2 : 1;
         end else begin
            m_rmode = 0;
         end
      end else if (rr) begin
         if (m_rmode == 1) begin
            m_ridx = m_ridx + 1;
            e_ren  = 1;
            if (m_ridx == FP - 1) m_rmode = 2;
         end else if (m_rmode == 2) begin
            e_rerr = 1;
         end
      end
      wrote = 0;
      if (wv) begin
         if (ws) begin
            if (!m_filling) begin
               m_wbank   = !m_disp;
               m_pending = 0;
            end else begin
               e_werr = 1;
            end
            m_widx = 0;
            wrote  = 1;
         end else if (m_filling) begin
            m_widx = m_widx + 1;
            wrote  = 1;
         end else begin
            e_werr = 1;
         end
      end
      if (wrote) begin
         e_wen   = 1;
         m_wdata = wd;
         if (m_widx == FP - 1) begin
            m_pending = 1; m_have_frame = 1; m_filling = 0;
            m_cnt = (m_cnt + 1) % 256;
         end else begin
            m_filling = 1;
         end
      end
   endtask

   task automatic check_model();
      chk("wr_en", wr_en_out, e_wen);
      chk("wr_bank", wr_bank_out, m_wbank);
      chk("wr_addr", wr_addr_out, m_widx);
      if (e_wen) chk("wr_data", wr_data_out, m_wdata);
      chk("wr_err", wr_err_out, e_werr);
      chk("rd_en", rd_en_out, e_ren);
      chk("rd_bank", rd_bank_out, m_disp);
      chk("rd_addr", rd_addr_out, m_ridx);
      chk("rd_err", rd_err_out, e_rerr);
      chk("blank", blank_out, m_blank);
      chk("frame_cnt", frame_cnt_out, m_cnt);
      if (wr_en_out) chk("no_tear", wr_bank_out != rd_bank_out, 1);
   endtask

   task automatic apply(input bit wv, input bit ws, input logic [DW-1:0] wd,
                        input bit rr, input bit rs);
      wr_valid_in = wv; wr_sof_in = ws; wr_data_in = wd;
      rd_req_in = rr; rd_sof_in = rs;
      model_step(wv, ws, wd, rr, rs);
      @(posedge clk);
      #1;
      check_model();
   endtask

   initial begin
      tbl[0]  = mk(0, 0, 24'h0,  1, 1,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0);
      tbl[1]  = mk(1, 1, 24'h1,  0, 0,  1, 1, 0,  0, 0, 0,  1, 0, 0, 0);
      tbl[2]  = mk(1, 0, 24'h2,  0, 0,  1, 1, 1,  0, 0, 0,  1, 0, 0, 0);
      tbl[3]  = mk(1, 0, 24'h3,  0, 0,  1, 1, 2,  0, 0, 0,  1, 0, 0, 0);
      tbl[4]  = mk(1, 0, 24'h4,  0, 0,  1, 1, 3,  0, 0, 0,  1, 0, 0, 1);
      tbl[5]  = mk(0, 0, 24'h0,  1, 1,  0, 1, 3,  1, 1, 0,  0, 0, 0, 1);
      tbl[6]  = mk(0, 0, 24'h0,  1, 0,  0, 1, 3,  1, 1, 1,  0, 0, 0, 1);
      tbl[7]  = mk(1, 1, 24'h10, 1, 0,  1, 0, 0,  1, 1, 2,  0, 0, 0, 1);
      tbl[8]  = mk(1, 0, 24'h11, 1, 0,  1, 0, 1,  1, 1, 3,  0, 0, 0, 1);
      tbl[9]  = mk(1, 0, 24'h12, 0, 0,  1, 0, 2,  0, 1, 3,  0, 0, 0, 1);
      tbl[10] = mk(1, 0, 24'h13, 0, 0,  1, 0, 3,  0, 1, 3,  0, 0, 0, 2);
      tbl[11] = mk(0, 0, 24'h0,  1, 0,  0, 0, 3,  0, 1, 3,  0, 0, 1, 2);
      tbl[12] = mk(0, 0, 24'h0,  1, 1,  0, 0, 3,  1, 0, 0,  0, 0, 0, 2);
      tbl[13] = mk(1, 1, 24'h20, 0, 0,  1, 1, 0,  0, 0, 0,  0, 0, 0, 2);
      tbl[14] = mk(1, 0, 24'h21, 0, 0,  1, 1, 1,  0, 0, 0,  0, 0, 0, 2);
      tbl[15] = mk(1, 0, 24'h22, 0, 0,  1, 1, 2,  0, 0, 0,  0, 0, 0, 2);
      tbl[16] = mk(1, 0, 24'h23, 0, 0,  1, 1, 3,  0, 0, 0,  0, 0, 0, 3);
      tbl[17] = mk(1, 1, 24'h30, 1, 1,  1, 0, 0,  1, 1, 0,  0, 0, 0, 3);
      tbl[18] = mk(1, 0, 24'h31, 0, 0,  1, 0, 1,  0, 1, 0,  0, 0, 0, 3);
      tbl[19] = mk(1, 1, 24'h32, 0, 0,  1, 0, 0,  0, 1, 0,  0, 1, 0, 3);
      tbl[20] = mk(1, 0, 24'h33, 0, 0,  1, 0, 1,  0, 1, 0,  0, 0, 0, 3);
      tbl[21] = mk(0, 0, 24'h0,  1, 0,  0, 0, 1,  1, 1, 1,  0, 0, 0, 3);
      tbl[22] = mk(0, 0, 24'h0,  1, 0,  0, 0, 1,  1, 1, 2,  0, 0, 0, 3);
      tbl[23] = mk(0, 0, 24'h0,  1, 0,  0, 0, 1,  1, 1, 3,  0, 0, 0, 3);
      tbl[24] = mk(0, 0, 24'h0,  1, 0,  0, 0, 1,  0, 1, 3,  0, 0, 1, 3);
      tbl[25] = mk(1, 0, 24'h34, 0, 0,  1, 0, 2,  0, 1, 3,  0, 0, 0, 3);
      tbl[26] = mk(1, 0, 24'h35, 0, 0,  1, 0, 3,  0, 1, 3,  0, 0, 0, 4);
      tbl[27] = mk(1, 0, 24'h36, 0, 0,  0, 0, 3,  0, 1, 3,  0, 1, 0, 4);

      reset = 1'b0;
      wr_valid_in = 0; wr_sof_in = 0; wr_data_in = '0; rd_req_in = 0; rd_sof_in = 0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      chk("rst_wr_en", wr_en_out, 0);
      chk("rst_rd_en", rd_en_out, 0);
      chk("rst_blank", blank_out, 1);
      chk("rst_frame_cnt", frame_cnt_out, 0);
      chk("rst_rd_bank", rd_bank_out, 0);

      for (int i = 0; i < 28; i++) begin
         apply(tbl[i].wv, tbl[i].ws, tbl[i].wd, tbl[i].rr, tbl[i].rs);
         chk($sformatf("tbl%0d_wr_en", i), wr_en_out, tbl[i].wen);
         chk($sformatf("tbl%0d_wr_bank", i), wr_bank_out, tbl[i].wbank);
         chk($sformatf("tbl%0d_wr_addr", i), wr_addr_out, tbl[i].waddr);
         if (tbl[i].wen) chk($sformatf("tbl%0d_wr_data", i), wr_data_out, tbl[i].wd);
         chk($sformatf("tbl%0d_rd_en", i), rd_en_out, tbl[i].ren);
         chk($sformatf("tbl%0d_rd_bank", i), rd_bank_out, tbl[i].rbank);
         chk($sformatf("tbl%0d_rd_addr", i), rd_addr_out, tbl[i].raddr);
         chk($sformatf("tbl%0d_blank", i), blank_out, tbl[i].blank);
         chk($sformatf("tbl%0d_wr_err", i), wr_err_out, tbl[i].werr);
         chk($sformatf("tbl%0d_rd_err", i), rd_err_out, tbl[i].rerr);
         chk($sformatf("tbl%0d_frame_cnt", i), frame_cnt_out, tbl[i].cnt);
      end

      // Asynchronous reset in the middle of a frame write.
      apply(1, 1, 24'h40, 0, 0);
      apply(1, 0, 24'h41, 0, 0);
      wr_valid_in = 1; wr_data_in = 24'h42;
      #2;
      reset = 1'b0;
      #1;
      chk("arst_wr_en", wr_en_out, 0);
      chk("arst_wr_addr", wr_addr_out, 0);
      chk("arst_wr_bank", wr_bank_out, 0);
      chk("arst_blank", blank_out, 1);
      chk("arst_frame_cnt", frame_cnt_out, 0);
      chk("arst_rd_bank", rd_bank_out, 0);
      wr_valid_in = 0; wr_data_in = '0;
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      apply(0, 0, 24'h0, 1, 1);
      chk("post_rst_rd_en", rd_en_out, 0);
      chk("post_rst_blank", blank_out, 1);

      // 256 complete frames bring the 8-bit counter back to zero.
      for (int f = 0; f < 256; f++) begin
         apply(1, 1, DW'(f), 0, 0);
         for (int p = 1; p < FP; p++) apply(1, 0, DW'(f * 16 + p), 0, 0);
      end
      chk("cnt_wrap", frame_cnt_out, 0);

      for (int n = 0; n < 3000; n++) begin
         apply($urandom_range(3, 0) != 0, $urandom_range(7, 0) == 0, DW'($urandom),
               $urandom_range(3, 0) != 0, $urandom_range(9, 0) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
